// File: rtl/pr_uart_tx_pkg.sv
// Shared definitions for the pr_uart_tx transmit peripheral: register map,
// STATUS/CTRL bit positions, FSM encoding and 8N1 frame geometry.
package pr_uart_tx_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A zero divisor would never terminate a bit time, so it is promoted to 1.
  function automatic logic [15:0] sanitize_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO for the transmit path; pointers carry an extra MSB so
// full and empty are distinguished without a separate flag.
module tx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d;
  logic [AW:0]       rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
  assign count_o = CNT_W'(wr_q - rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pr_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register file, transmit FIFO, baud-timed
// shifter and a level interrupt raised when the FIFO drains and the line idles.
module pr_uart_tx
  import pr_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          CNT_W       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        TxD,
  output logic        IRQ
);

  logic [1:0]       ctrl_q, ctrl_d;
  logic [15:0]      div_q, div_d;
  logic             ovf_q, ovf_d;
  tx_state_e        state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic             txd_q, txd_d;
  logic             irq_q, irq_d;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      bit_div_q, bit_div_d;

  logic             wr_data, wr_status, wr_div, wr_ctrl;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             tx_en, irq_en, busy;
  logic             baud_end, start_ok;
  logic [31:0]      status;
  logic             unused_din;

  assign wr_data   = WE && (Addr == ADDR_DATA);
  assign wr_status = WE && (Addr == ADDR_STATUS);
  assign wr_div    = WE && (Addr == ADDR_DIVISOR);
  assign wr_ctrl   = WE && (Addr == ADDR_CTRL);

  assign tx_en      = ctrl_q[CTRL_TX_EN];
  assign irq_en     = ctrl_q[CTRL_IRQ_EN];
  assign busy       = (state_q != S_IDLE);
  assign unused_din = ^Din[31:16];

  tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (sys_rstn),
    .push_i  (wr_data),
    .pop_i   (pop),
    .data_i  (Din[7:0]),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    div_d  = div_q;
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    if (wr_div)                        div_d  = sanitize_div(Din[15:0]);
    if (wr_ctrl)                       ctrl_d = Din[1:0];
    if (wr_status && Din[ST_OVF])      ovf_d  = 1'b0;
    if (wr_data && fifo_full && !pop)  ovf_d  = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    pop       = 1'b0;
    baud_end  = (baud_q == (bit_div_q - 16'd1));
    start_ok  = tx_en && !fifo_empty;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          bit_div_d = div_q;
          bitcnt_d  = 3'd0;
          baud_d    = 16'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bitcnt_q == 3'(DATA_BITS - 1)) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (start_ok) begin
            pop       = 1'b1;
            shift_d   = fifo_head;
            bit_div_d = div_q;
            bitcnt_d  = 3'd0;
            baud_d    = 16'd0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    txd_d = (state_d == S_DATA) ? shift_d[0] : (state_d != S_START);
    irq_d = irq_en && fifo_empty && !busy;
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      ctrl_q   <= 2'b00;
      div_q    <= DEFAULT_DIV;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bitcnt_q <= 3'd0;
      txd_q    <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitcnt_q <= bitcnt_d;
      txd_q    <= txd_d;
      irq_q    <= irq_d;
    end
  end

  // Frame datapath is only observed outside IDLE, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    bit_div_q <= bit_div_d;
  end

  always_comb begin
    status                           = 32'd0;
    status[ST_BUSY]                  = busy;
    status[ST_FULL]                  = fifo_full;
    status[ST_EMPTY]                 = fifo_empty;
    status[ST_OVF]                   = ovf_q;
    status[ST_CNT_LSB +: CNT_W]      = fifo_count;
    case (Addr)
      ADDR_DATA:    Dout = 32'd0;
      ADDR_STATUS:  Dout = status;
      ADDR_DIVISOR: Dout = {16'd0, div_q};
      ADDR_CTRL:    Dout = {30'd0, ctrl_q};
      default:      Dout = 32'd0;
    endcase
  end

  assign TxD = txd_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_pr_uart_tx.sv
// Directed self-checking bench for pr_uart_tx: register map, frame timing,
// back-to-back frames, overflow, mid-frame divisor change and async reset.
module tb_pr_uart_tx;
  import pr_uart_tx_pkg::*;

  logic        clk;
  logic        sys_rstn;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        TxD;
  logic        IRQ;

  int n_checks;
  int n_errors;

  pr_uart_tx #(
    .FIFO_DEPTH  (8),
    .CNT_W       (4),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .Addr     (Addr),
    .WE       (WE),
    .Din      (Din),
    .Dout     (Dout),
    .TxD      (TxD),
    .IRQ      (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1ns after that edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Addr = ADDR_STATUS;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    Addr = a;
    #1;
    v    = Dout;
    Addr = ADDR_STATUS;
  endtask

  // Checks one full frame cycle by cycle, starting at the next falling edge.
  // Optionally injects a register write after check cycle 'inj'.
  task automatic expect_frame(input logic [7:0] b, input int div, input int inj,
                              input logic [1:0] ia, input logic [31:0] id, input string tag);
    logic [9:0] fr;
    logic       bexp;
    fr = {1'b1, b, 1'b0};
    for (int c = 0; c < FRAME_BITS * div; c++) begin
      @(negedge clk);
      if (WE) begin
        WE   = 1'b0;
        Addr = ADDR_STATUS;
        Din  = 32'd0;
      end
      #1;
      bexp = fr[c / div];
      check({tag, "_txd"},  {31'd0, TxD},     {31'd0, bexp});
      check({tag, "_busy"}, {31'd0, Dout[0]}, 32'd1);
      check({tag, "_irq"},  {31'd0, IRQ},     32'd0);
      if (c == inj) begin
        Addr = ia;
        Din  = id;
        WE   = 1'b1;
      end
    end
  endtask

  logic [31:0] v;

  initial begin
    n_checks = 0;
    n_errors = 0;
    sys_rstn = 1'b0;
    Addr     = ADDR_STATUS;
    WE       = 1'b0;
    Din      = 32'd0;
    repeat (3) @(negedge clk);
    sys_rstn = 1'b1;

    // Reset state
    #1;
    check("rst_txd", {31'd0, TxD}, 32'd1);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    rd(ADDR_STATUS, v);  check("rst_status", v, 32'h04);
    rd(ADDR_DIVISOR, v); check("rst_div", v, 32'd434);
    rd(ADDR_CTRL, v);    check("rst_ctrl", v, 32'd0);
    rd(ADDR_DATA, v);    check("rst_data", v, 32'd0);

    // Single frame 0xA5 at 4 cycles per bit
    wr(ADDR_DIVISOR, 32'd4);
    wr(ADDR_CTRL, 32'd1);
    wr(ADDR_DATA, 32'hA5);
    @(negedge clk); #1;
    check("a5_latency_txd", {31'd0, TxD}, 32'd1);
    expect_frame(8'hA5, 4, -1, ADDR_STATUS, 32'd0, "a5");
    @(negedge clk); #1;
    check("a5_done_busy", {31'd0, Dout[0]}, 32'd0);
    check("a5_done_txd", {31'd0, TxD}, 32'd1);

    // Back-to-back frames with IRQ enabled
    wr(ADDR_DIVISOR, 32'd2);
    wr(ADDR_CTRL, 32'd3);
    wr(ADDR_DATA, 32'h01);
    wr(ADDR_DATA, 32'h80);
    expect_frame(8'h01, 2, -1, ADDR_STATUS, 32'd0, "b2b0");
    expect_frame(8'h80, 2, -1, ADDR_STATUS, 32'd0, "b2b1");
    @(negedge clk); #1;
    check("b2b_idle_status", Dout, 32'h04);
    check("b2b_irq_lag", {31'd0, IRQ}, 32'd0);
    @(negedge clk); #1;
    check("b2b_irq_rise", {31'd0, IRQ}, 32'd1);

    // Overflow with transmitter disabled, then drain in order
    wr(ADDR_CTRL, 32'd0);
    for (int i = 0; i < 9; i++) wr(ADDR_DATA, 32'h10 + i);
    rd(ADDR_STATUS, v); check("ovf_status", v, 32'h8A);
    check("ovf_txd", {31'd0, TxD}, 32'd1);
    wr(ADDR_STATUS, 32'h08);
    rd(ADDR_STATUS, v); check("ovf_clr_status", v, 32'h82);
    wr(ADDR_CTRL, 32'd1);
    @(negedge clk); #1;
    check("drain_latency_txd", {31'd0, TxD}, 32'd1);
    for (int i = 0; i < 8; i++) expect_frame(8'(8'h10 + i), 2, -1, ADDR_STATUS, 32'd0, "drain");
    rd(ADDR_STATUS, v); check("drain_status", v, 32'h04);

    // Divisor change mid-frame applies only from the next frame
    wr(ADDR_DIVISOR, 32'd4);
    wr(ADDR_DATA, 32'h3C);
    wr(ADDR_DATA, 32'hC3);
    expect_frame(8'h3C, 4, 10, ADDR_DIVISOR, 32'd8, "mid0");
    expect_frame(8'hC3, 8, -1, ADDR_STATUS, 32'd0, "mid1");
    @(negedge clk); #1;
    check("mid_done_busy", {31'd0, Dout[0]}, 32'd0);
    wr(ADDR_DIVISOR, 32'd0);
    rd(ADDR_DIVISOR, v); check("div_zero", v, 32'd1);

    // Asynchronous reset during data bit 3
    wr(ADDR_DIVISOR, 32'd4);
    wr(ADDR_DATA, 32'h55);
    wr(ADDR_DATA, 32'hFF);
    for (int c = 0; c < 18; c++) @(negedge clk);
    #1;
    check("arst_pre_txd", {31'd0, TxD}, 32'd0);
    sys_rstn = 1'b0;
    #1;
    check("arst_txd", {31'd0, TxD}, 32'd1);
    check("arst_status", Dout, 32'h04);
    @(negedge clk);
    sys_rstn = 1'b1;
    rd(ADDR_DIVISOR, v); check("arst_div", v, 32'd434);
    wr(ADDR_CTRL, 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      check("arst_idle_txd", {31'd0, TxD}, 32'd1);
      check("arst_idle_status", Dout, 32'h04);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
